// File: rtl/reg_sequencer_if.sv
// Instruction handshake, register-file port and status bundle for reg_sequencer.
// master = instruction source and register file; slave = the sequencer itself.
interface reg_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        instr;
    logic [DATA_W-1:0] imm;
    logic              instr_valid;
    logic              instr_ready;
    logic              rf_rw;
    logic              rf_wsel;
    logic [1:0]        rf_rsel;
    logic [DATA_W-1:0] rf_w;
    logic [DATA_W-1:0] rf_read0;
    logic [DATA_W-1:0] rf_read1;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              done;

    modport master (
        output instr, imm, instr_valid, rf_read0, rf_read1,
        input  instr_ready, rf_rw, rf_wsel, rf_rsel, rf_w, result, carry, done
    );

    modport slave (
        input  instr, imm, instr_valid, rf_read0, rf_read1,
        output instr_ready, rf_rw, rf_wsel, rf_rsel, rf_w, result, carry, done
    );
endinterface

// File: rtl/reg_sequencer.sv
// Sequences LOADI/ADD/SUB/MOV over an external two-entry register file (A, B).
// Latency: done pulses 4 cycles after accept for ALU ops, 2 cycles for LOADI.
// Backpressure: instr_ready is high only in IDLE; upstream holds instr/imm while busy.
module reg_sequencer #(
    parameter int DATA_W = 8
) (
    input logic            sysclk,
    input logic            resetn,
    reg_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_MOV   = 2'b11;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op_q;
    logic              dst_q;
    logic              swap_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              done_q;

    logic              instr_ready;
    logic              rf_rw;
    logic              rf_wsel;
    logic [1:0]        rf_rsel;
    logic              accept;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic              unused_instr_bits;

    assign accept   = bus.instr_valid && instr_ready;
    // Top bit of the extended difference is the borrow, i.e. x < y.
    assign sum_ext  = {1'b0, bus.rf_read0} + {1'b0, bus.rf_read1};
    assign diff_ext = {1'b0, bus.rf_read0} - {1'b0, bus.rf_read1};
    assign unused_instr_bits = ^bus.instr[3:0];

    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_rw       = 1'b0;
        rf_wsel     = 1'b0;
        rf_rsel     = 2'b00;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = (bus.instr[7:6] == OP_LOADI) ? WRITE : READ;
                end
            end
            READ: begin
                rf_rsel   = swap_q ? 2'b10 : 2'b01;
                state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                rf_rw     = 1'b1;
                rf_wsel   = dst_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // LOADI parks imm in result at accept so the WRITE cycle just drives result.
    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= OP_LOADI;
            dst_q    <= 1'b0;
            swap_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == WRITE);
            if (accept) begin
                op_q   <= bus.instr[7:6];
                dst_q  <= bus.instr[5];
                swap_q <= bus.instr[4];
                if (bus.instr[7:6] == OP_LOADI) begin
                    result_q <= bus.imm;
                end
            end
            if (state == EXEC) begin
                case (op_q)
                    OP_ADD: begin
                        result_q <= sum_ext[DATA_W-1:0];
                        carry_q  <= sum_ext[DATA_W];
                    end
                    OP_SUB: begin
                        result_q <= diff_ext[DATA_W-1:0];
                        carry_q  <= diff_ext[DATA_W];
                    end
                    OP_MOV: begin
                        result_q <= bus.rf_read0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.rf_rw       = rf_rw;
    assign bus.rf_wsel     = rf_wsel;
    assign bus.rf_rsel     = rf_rsel;
    assign bus.rf_w        = result_q;
    assign bus.result      = result_q;
    assign bus.carry       = carry_q;
    assign bus.done        = done_q;
endmodule
